tcm_lsu_port: RTL and testbench



---
 rtl/mem_defines_pkg.sv | 19 +
 rtl/tcm_lsu_align.sv | 64 ++++++
 rtl/tcm_lsu_port.sv | 160 ++++++++++++++++
 tb/tb_tcm_lsu_port.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_defines_pkg.sv
// Shared data-memory definitions for the TCM load/store path.
//   mem_size_t  : access size encoding carried on the core data bus
//                 (encoding 3 is illegal and is flagged as an error).
//   lsu_state_t : response-path states of tcm_lsu_port.
package mem_defines;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,  // no response pending
    LSU_LIVE = 2'd1,  // response formatted straight from RAM read data
    LSU_HELD = 2'd2   // response replayed from the hold register
  } lsu_state_t;

endpackage

// File: rtl/tcm_lsu_align.sv
// Combinational lane steering for the TCM load/store port.
// Store side : builds byte write strobes and replicates the right-aligned
//              store data onto every lane it may land in.
// Load side  : picks the addressed byte/half out of the RAM word, moves it
//              to bit 0 and sign- or zero-extends it.
// Ports:
//   st_offset/st_size/st_wdata -> st_strb, st_data   (store path)
//   ld_raw/ld_offset/ld_size/ld_unsigned -> ld_data  (load path)
module tcm_lsu_align
  import mem_defines::*;
(
  input  logic [1:0]  st_offset,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_strb,
  output logic [31:0] st_data,
  input  logic [31:0] ld_raw,
  input  logic [1:0]  ld_offset,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Store: illegal size yields no strobes; data passes through unchanged.
  always_comb begin
    st_strb = 4'b0000;
    st_data = st_wdata;
    case (st_size)
      MEM_BYTE: begin
        st_strb = 4'b0001 << st_offset;
        st_data = {4{st_wdata[7:0]}};
      end
      MEM_HALF: begin
        st_strb = st_offset[1] ? 4'b1100 : 4'b0011;
        st_data = {2{st_wdata[15:0]}};
      end
      MEM_WORD: begin
        st_strb = 4'b1111;
      end
      default: ;
    endcase
  end

  // Load: lane select then extension; word loads ignore ld_unsigned.
  always_comb begin
    ld_byte = 8'h00;
    case (ld_offset)
      2'd0:    ld_byte = ld_raw[7:0];
      2'd1:    ld_byte = ld_raw[15:8];
      2'd2:    ld_byte = ld_raw[23:16];
      default: ld_byte = ld_raw[31:24];
    endcase
    ld_half = ld_offset[1] ? ld_raw[31:16] : ld_raw[15:0];
    case (ld_size)
      MEM_BYTE: ld_data = {{24{~ld_unsigned & ld_byte[7]}}, ld_byte};
      MEM_HALF: ld_data = {{16{~ld_unsigned & ld_half[15]}}, ld_half};
      default:  ld_data = ld_raw;
    endcase
  end

endmodule

// File: rtl/tcm_lsu_port.sv
// Single-outstanding load/store adapter between the core data bus and one
// port of the dual-port TCM RAM.
// Handshake: a request transfers on a cycle where req_valid_i & req_ready_o;
// a response transfers on a cycle where rsp_valid_o & rsp_ready_i. Once
// raised, rsp_valid_o and its payload stay stable until the transfer.
// Ports:
//   clk_i, rst_n_i              clock, synchronous active-low reset
//   req_*                       core request (address, size, store data)
//   rsp_*                       core response (load data, error)
//   ram_addr_o/ram_data_o/ram_wr_o/ram_data_i   TCM RAM port (1-cycle read)
module tcm_lsu_port
  import mem_defines::*;
#(
  parameter int          ADDR_WIDTH = 16,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_addr_i,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [31:0]           req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [31:0]           rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic [ADDR_WIDTH-3:0] ram_addr_o,
  output logic [31:0]           ram_data_o,
  output logic [3:0]            ram_wr_o,
  input  logic [31:0]           ram_data_i
);

  lsu_state_t state, state_nxt;

  logic                  accept;
  logic                  rsp_fire;
  logic                  req_err;
  logic                  misaligned;
  logic                  out_of_window;
  logic [3:0]            st_strb;
  logic [31:0]           ld_data;
  logic [31:0]           live_rdata;

  // Attributes of the last accepted request, needed to format its response.
  logic [ADDR_WIDTH-3:0] addr_q;
  logic [1:0]            offset_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic                  we_q;
  logic                  err_q;

  logic [31:0]           hold_rdata;
  logic                  hold_err;

  // Handshake. Gating with rst_n_i drops a pending response and blocks any
  // accept (and therefore any RAM write) in the cycle reset is asserted.
  assign rsp_valid_o = rst_n_i & (state != LSU_IDLE);
  assign rsp_fire    = rsp_valid_o & rsp_ready_i;
  assign req_ready_o = rst_n_i & ((state == LSU_IDLE) | rsp_fire);
  assign accept      = req_valid_i & req_ready_o;

  // Request checks.
  always_comb begin
    misaligned = 1'b0;
    case (req_size_i)
      MEM_HALF: misaligned = req_addr_i[0];
      MEM_WORD: misaligned = (req_addr_i[1:0] != 2'b00);
      default:  misaligned = 1'b0;
    endcase
  end

  assign out_of_window = (req_addr_i[31:ADDR_WIDTH] != BASE_ADDR[31:ADDR_WIDTH]);
  assign req_err       = (req_size_i == 2'd3) | misaligned | out_of_window;

  tcm_lsu_align u_align (
    .st_offset   (req_addr_i[1:0]),
    .st_size     (req_size_i),
    .st_wdata    (req_wdata_i),
    .st_strb     (st_strb),
    .st_data     (ram_data_o),
    .ld_raw      (ram_data_i),
    .ld_offset   (offset_q),
    .ld_size     (size_q),
    .ld_unsigned (unsigned_q),
    .ld_data     (ld_data)
  );

  // RAM side: the index is live in the accept cycle so the RAM registers it
  // at that edge; afterwards it parks on the last accepted word.
  assign ram_addr_o = accept ? req_addr_i[ADDR_WIDTH-1:2] : addr_q;
  assign ram_wr_o   = (accept & req_we_i & ~req_err) ? st_strb : 4'b0000;

  // Stores and errored requests always answer with zero data.
  assign live_rdata = (err_q | we_q) ? 32'h0 : ld_data;

  always_comb begin
    rsp_rdata_o = 32'h0;
    rsp_err_o   = 1'b0;
    if (rst_n_i) begin
      case (state)
        LSU_LIVE: begin
          rsp_rdata_o = live_rdata;
          rsp_err_o   = err_q;
        end
        LSU_HELD: begin
          rsp_rdata_o = hold_rdata;
          rsp_err_o   = hold_err;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LSU_IDLE: if (accept) state_nxt = LSU_LIVE;
      LSU_LIVE: begin
        if (rsp_ready_i) state_nxt = accept ? LSU_LIVE : LSU_IDLE;
        else             state_nxt = LSU_HELD;
      end
      LSU_HELD: if (rsp_ready_i) state_nxt = accept ? LSU_LIVE : LSU_IDLE;
      default:  state_nxt = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state      <= LSU_IDLE;
      addr_q     <= '0;
      offset_q   <= 2'b00;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      hold_rdata <= 32'h0;
      hold_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q     <= req_addr_i[ADDR_WIDTH-1:2];
        offset_q   <= req_addr_i[1:0];
        size_q     <= req_size_i;
        unsigned_q <= req_unsigned_i;
        we_q       <= req_we_i;
        err_q      <= req_err;
      end
      // RAM read data is only valid in the LIVE cycle; freeze it if the core
      // stalls so the other port cannot disturb the pending response.
      if (state == LSU_LIVE && !rsp_ready_i) begin
        hold_rdata <= live_rdata;
        hold_err   <= err_q;
      end
    end
  end

endmodule

// File: tb/tb_tcm_lsu_port.sv
// Bench for tcm_lsu_port: table of single transactions plus hand-written
// sequences for back-pressure, back-to-back bursts and reset mid-burst.
module tb_tcm_lsu_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [13:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wr;
  logic [31:0] ram_rd;

  // Second RAM port (stands in for instruction side / other writer).
  logic        mem_clr;
  logic        p1_we;
  logic [13:0] p1_addr;
  logic [31:0] p1_data;
  logic [31:0] mem [0:16383];

  int n_vec;
  int n_miss;

  tcm_lsu_port #(.ADDR_WIDTH(16), .BASE_ADDR(32'h0000_0000)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .req_addr_i     (req_addr),
    .req_we_i       (req_we),
    .req_size_i     (req_size),
    .req_unsigned_i (req_unsigned),
    .req_wdata_i    (req_wdata),
    .rsp_valid_o    (rsp_valid),
    .rsp_ready_i    (rsp_ready),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_err_o      (rsp_err),
    .ram_addr_o     (ram_addr),
    .ram_data_o     (ram_wdata),
    .ram_wr_o       (ram_wr),
    .ram_data_i     (ram_rd)
  );

  // ---------------- clock / RAM model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first registered RAM with byte enables.
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16384; i++) mem[i] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wr[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      if (p1_we) mem[p1_addr] <= p1_data;
    end
    ram_rd <= mem[ram_addr];
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  e_wr;
    logic [13:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // One full transaction with rsp_ready high: accept-cycle RAM checks, then
  // response checks in the following cycle.
  task automatic apply_vec(input vec_t v);
    @(negedge clk);
    rsp_ready = 1'b1;
    drive_req(v.we, v.size, v.uns, v.addr, v.wdata);
    #1;
    chk({v.name, ".req_ready"}, {31'h0, req_ready}, 32'h1);
    chk({v.name, ".ram_wr"},    {28'h0, ram_wr}, {28'h0, v.e_wr});
    chk({v.name, ".ram_addr"},  {18'h0, ram_addr}, {18'h0, v.e_addr});
    chk({v.name, ".ram_data"},  ram_wdata, v.e_wdata);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk({v.name, ".rsp_valid"}, {31'h0, rsp_valid}, 32'h1);
    chk({v.name, ".rdata"},     rsp_rdata, v.e_rdata);
    chk({v.name, ".err"},       {31'h0, rsp_err}, {31'h0, v.e_err});
  endtask

  // n back-to-back word accesses at base, data 0xA000_0000+k for stores.
  task automatic burst(input logic we, input logic [31:0] base, input int n);
    for (int k = 0; k <= n; k++) begin
      @(negedge clk);
      rsp_ready = 1'b1;
      if (k < n) drive_req(we, 2'd2, 1'b0, base + 32'(4 * k), we ? 32'hA000_0000 + 32'(k) : 32'h0);
      else       req_valid = 1'b0;
      #1;
      if (k >= 1) begin
        chk("burst.rsp_valid", {31'h0, rsp_valid}, 32'h1);
        chk("burst.rdata", rsp_rdata, we ? 32'h0 : 32'hA000_0000 + 32'(k - 1));
      end
      if (k < n) begin
        chk("burst.req_ready", {31'h0, req_ready}, 32'h1);
        chk("burst.ram_wr", {28'h0, ram_wr}, we ? 32'hF : 32'h0);
      end
    end
    @(negedge clk);
    #1;
    chk("burst.drain", {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1);
  end

  // ---------------- test ----------------
  initial begin
    n_vec = 0; n_miss = 0;
    rst_n = 1'b0; mem_clr = 1'b1; rsp_ready = 1'b1;
    p1_we = 1'b0; p1_addr = '0; p1_data = '0;
    // A store presented during reset must never reach the RAM.
    drive_req(1'b1, 2'd2, 1'b0, 32'h100, 32'hFFFF_FFFF);

    //      name         we sz u  addr         wdata         wr    idx     ram_data      rdata         err
    vecs.push_back('{"st_w_100",  1'b1, 2'd2, 1'b0, 32'h100,   32'hDEADBEEF, 4'hF, 14'h40, 32'hDEADBEEF, 32'h0,        1'b0});
    vecs.push_back('{"ld_w_100",  1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        4'h0, 14'h40, 32'h0,        32'hDEADBEEF, 1'b0});
    vecs.push_back('{"st_b_103",  1'b1, 2'd0, 1'b0, 32'h103,   32'h00000080, 4'h8, 14'h40, 32'h80808080, 32'h0,        1'b0});
    vecs.push_back('{"ld_b_103s", 1'b0, 2'd0, 1'b0, 32'h103,   32'h0,        4'h0, 14'h40, 32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{"ld_b_103u", 1'b0, 2'd0, 1'b1, 32'h103,   32'h0,        4'h0, 14'h40, 32'h0,        32'h00000080, 1'b0});
    vecs.push_back('{"ld_w_100b", 1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        4'h0, 14'h40, 32'h0,        32'h80ADBEEF, 1'b0});
    vecs.push_back('{"st_w_104",  1'b1, 2'd2, 1'b0, 32'h104,   32'h00008001, 4'hF, 14'h41, 32'h00008001, 32'h0,        1'b0});
    vecs.push_back('{"st_h_106",  1'b1, 2'd1, 1'b0, 32'h106,   32'hABCD1234, 4'hC, 14'h41, 32'h12341234, 32'h0,        1'b0});
    vecs.push_back('{"ld_h_104s", 1'b0, 2'd1, 1'b0, 32'h104,   32'h0,        4'h0, 14'h41, 32'h0,        32'hFFFF8001, 1'b0});
    vecs.push_back('{"ld_h_104u", 1'b0, 2'd1, 1'b1, 32'h104,   32'h0,        4'h0, 14'h41, 32'h0,        32'h00008001, 1'b0});
    vecs.push_back('{"ld_h_106s", 1'b0, 2'd1, 1'b0, 32'h106,   32'h0,        4'h0, 14'h41, 32'h0,        32'h00001234, 1'b0});
    vecs.push_back('{"ld_b_105s", 1'b0, 2'd0, 1'b0, 32'h105,   32'h0,        4'h0, 14'h41, 32'h0,        32'hFFFFFF80, 1'b0});
    vecs.push_back('{"ld_b_104u", 1'b0, 2'd0, 1'b1, 32'h104,   32'h0,        4'h0, 14'h41, 32'h0,        32'h00000001, 1'b0});
    vecs.push_back('{"ld_w_u104", 1'b0, 2'd2, 1'b1, 32'h104,   32'h0,        4'h0, 14'h41, 32'h0,        32'h12348001, 1'b0});
    vecs.push_back('{"ld_w_102",  1'b0, 2'd2, 1'b0, 32'h102,   32'h0,        4'h0, 14'h40, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"st_w_oow",  1'b1, 2'd2, 1'b0, 32'h10000, 32'h11111111, 4'h0, 14'h00, 32'h11111111, 32'h0,        1'b1});
    vecs.push_back('{"ld_w_000",  1'b0, 2'd2, 1'b0, 32'h0,     32'h0,        4'h0, 14'h00, 32'h0,        32'h0,        1'b0});
    vecs.push_back('{"ld_b_oow",  1'b0, 2'd0, 1'b0, 32'h10100, 32'h0,        4'h0, 14'h40, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"ld_sz3",    1'b0, 2'd3, 1'b0, 32'h100,   32'h0,        4'h0, 14'h40, 32'h0,        32'h0,        1'b1});
    vecs.push_back('{"st_h_101",  1'b1, 2'd1, 1'b0, 32'h101,   32'h0000FFFF, 4'h0, 14'h40, 32'hFFFFFFFF, 32'h0,        1'b1});
    vecs.push_back('{"st_sz3",    1'b1, 2'd3, 1'b0, 32'h100,   32'h77777777, 4'h0, 14'h40, 32'h77777777, 32'h0,        1'b1});
    vecs.push_back('{"ld_w_100c", 1'b0, 2'd2, 1'b0, 32'h100,   32'h0,        4'h0, 14'h40, 32'h0,        32'h80ADBEEF, 1'b0});

    // ---- reset state ----
    repeat (3) @(negedge clk);
    #1;
    chk("rst.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rst.rdata",     rsp_rdata, 32'h0);
    chk("rst.err",       {31'h0, rsp_err}, 32'h0);
    chk("rst.ram_wr",    {28'h0, ram_wr}, 32'h0);
    chk("rst.ram_addr",  {18'h0, ram_addr}, 32'h0);
    chk("rst.req_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    mem_clr = 1'b0; rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);

    // ---- vector table ----
    foreach (vecs[i]) apply_vec(vecs[i]);

    // ---- back-pressure: response held 3 cycles while port 1 overwrites ----
    @(negedge clk);
    rsp_ready = 1'b0;
    drive_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
    @(negedge clk);
    req_valid = 1'b0;
    p1_we = 1'b1; p1_addr = 14'h40; p1_data = 32'h5555_5555;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold.rsp_valid", {31'h0, rsp_valid}, 32'h1);
      chk("hold.rdata",     rsp_rdata, 32'h80ADBEEF);
      chk("hold.err",       {31'h0, rsp_err}, 32'h0);
      chk("hold.req_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
      p1_we = 1'b0;
    end
    rsp_ready = 1'b1;
    #1;
    chk("hold.release_ready", {31'h0, req_ready}, 32'h1);
    chk("hold.release_rdata", rsp_rdata, 32'h80ADBEEF);
    @(negedge clk);
    #1;
    chk("hold.done", {31'h0, rsp_valid}, 32'h0);
    // Confirms the overwrite really landed while the response was held.
    apply_vec('{"ld_after_p1", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 4'h0, 14'h40, 32'h0, 32'h55555555, 1'b0});

    // ---- back-to-back: 8 stores then 8 loads, one per cycle ----
    burst(1'b1, 32'h200, 8);
    burst(1'b0, 32'h200, 8);

    // ---- reset asserted mid-burst of stores ----
    @(negedge clk);
    drive_req(1'b1, 2'd2, 1'b0, 32'h300, 32'hC000_0000);
    #1;
    chk("rstmid.wr0", {28'h0, ram_wr}, 32'hF);
    @(negedge clk);
    drive_req(1'b1, 2'd2, 1'b0, 32'h304, 32'hC000_0001);
    #1;
    chk("rstmid.wr1", {28'h0, ram_wr}, 32'hF);
    chk("rstmid.rsp0", {31'h0, rsp_valid}, 32'h1);
    @(negedge clk);
    drive_req(1'b1, 2'd2, 1'b0, 32'h308, 32'hC000_0002);
    rst_n = 1'b0;
    #1;
    chk("rstmid.wr_gated", {28'h0, ram_wr}, 32'h0);
    chk("rstmid.ready_gated", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    #1;
    chk("rstmid.rsp_valid", {31'h0, rsp_valid}, 32'h0);
    chk("rstmid.ram_wr",    {28'h0, ram_wr}, 32'h0);
    chk("rstmid.ram_addr",  {18'h0, ram_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; req_valid = 1'b0;
    apply_vec('{"rstmid.ld300", 1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 4'h0, 14'hC0, 32'h0, 32'hC0000000, 1'b0});
    apply_vec('{"rstmid.ld304", 1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 4'h0, 14'hC1, 32'h0, 32'hC0000001, 1'b0});
    apply_vec('{"rstmid.ld308", 1'b0, 2'd2, 1'b0, 32'h308, 32'h0, 4'h0, 14'hC2, 32'h0, 32'h00000000, 1'b0});

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
